// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants and drain FSM encoding for the TDC event queue
package tdc_pkg;
  localparam int TS_W = 40;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DROP_W = 32;
  localparam logic [7:0] OVF_MARKER_TAG = 8'hFF;
  typedef enum logic [1:0] {IDLE, SENT, DRAIN} drain_state_e;
endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: synchronous FIFO without fall-through; push while full is accepted only alongside a pop
// Ports: clk/rst (sync, active-high); push_i/wdata_i write side; pop_i/rdata_o read side (rdata_o is the head);
// full_o/empty_o status; level_o occupancy.
module tdc_sync_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic do_wr, do_rd;
  assign do_rd = pop_i & ~empty_o;
  assign do_wr = push_i & (~full_o | do_rd);
  assign rdata_o = mem_q[rd_q];
  assign full_o = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_q] <= wdata_i;
        wr_q <= wr_q + AW'(1);
      end
      if (do_rd) rd_q <= rd_q + AW'(1);
      level_q <= level_q + LW'(do_wr) - LW'(do_rd);
    end
  end
endmodule

// File: rtl/tdc_event_queue.sv
// tdc_event_queue: timestamps rising edges of an async hit and feeds them to a hex UART transmitter
// Ports: clk/rst (sync, active-high); event_in async hit; data/data_valid word and start pulse to the
// transmitter, paced by its busy; level FIFO occupancy; overflow sticky drop flag.
// Define TDC_OVF_MARKER_EN to count drops and send a {8'hFF, drop_count} marker before the next timestamp.
module tdc_event_queue #(
  parameter int DEPTH = tdc_pkg::DEFAULT_FIFO_DEPTH,
  parameter int TS_W = tdc_pkg::TS_W,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            event_in,
  output logic [TS_W-1:0] data,
  output logic            data_valid,
  input  logic            busy,
  output logic [LW-1:0]   level,
  output logic            overflow
);
  import tdc_pkg::*;
  drain_state_e state_q, state_d;
  logic s1_q, s2_q, s3_q, hit;
  logic [TS_W-1:0] cnt_q, data_q, data_d, head, marker;
  logic dv_q, dv_d, ovf_q, sent_q, sent_d;
  logic pop, full, empty, drop, mark;
  assign hit = s2_q & ~s3_q;
  assign drop = hit & full & ~pop;
  assign data = data_q;
  assign data_valid = dv_q;
  assign overflow = ovf_q;
  tdc_sync_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hit),
    .wdata_i (cnt_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
`ifdef TDC_OVF_MARKER_EN
  logic [DROP_W-1:0] drop_q, drop_base;
  assign mark = |drop_q;
  assign marker = TS_W'({OVF_MARKER_TAG, drop_q});
  // Sending the marker clears the count; a drop in that same cycle then counts as the first new one.
  assign drop_base = (dv_d & mark) ? '0 : drop_q;
  always_ff @(posedge clk)
    drop_q <= rst ? '0 : (drop && !(&drop_base)) ? drop_base + DROP_W'(1) : drop_base;
`else
  assign mark = 1'b0;
  assign marker = '0;
`endif
  always_comb begin
    state_d = state_q;
    sent_d = 1'b0;
    data_d = data_q;
    dv_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!busy && (mark || !empty)) begin
        dv_d = 1'b1;
        data_d = mark ? marker : head;
        pop = !mark;
        state_d = SENT;
      end
      // Give the transmitter two cycles to raise busy; if it never does, fall back to IDLE without re-sending.
      SENT: begin
        state_d = busy ? DRAIN : sent_q ? IDLE : SENT;
        sent_d = !busy && !sent_q;
      end
      DRAIN: state_d = busy ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s3_q, s2_q, s1_q} <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      sent_q <= 1'b0;
      data_q <= '0;
      dv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      {s3_q, s2_q, s1_q} <= {s2_q, s1_q, event_in};
      cnt_q <= cnt_q + TS_W'(1);
      state_q <= state_d;
      sent_q <= sent_d;
      data_q <= data_d;
      dv_q <= dv_d;
      ovf_q <= ovf_q | drop;
    end
  end
endmodule

// File: tb/tb_tdc_event_queue.sv
// tb_tdc_event_queue: directed scoreboard bench for tdc_event_queue
module tb_tdc_event_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic event_in = 1'b0;
  logic busy = 1'b0;
  logic [39:0] data;
  logic data_valid;
  logic [4:0] level;
  logic overflow;
  int n_chk = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int bcnt = 0;
  bit real_tx = 1'b0;
  logic [39:0] sb [$];
  logic [39:0] cnt_m = '0;
  logic [39:0] last_data = '0;
  logic [39:0] prev_data = '0;

  tdc_event_queue #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .event_in   (event_in),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: track the expected counter, check any emitted word, model the transmitter's busy.
  task automatic tick();
    logic [39:0] e;
    @(posedge clk);
    cnt_m = rst ? '0 : cnt_m + 40'd1;
    @(negedge clk);
    if (data_valid) begin
      dv_cnt++;
      chk("dv_while_busy", 40'(busy), 40'd0);
      chk("dv_expected", 40'(sb.size() != 0), 40'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", data, e);
      end
      prev_data = last_data;
      last_data = data;
    end
    if (real_tx) begin
      if (data_valid) begin
        busy = 1'b1;
        bcnt = 110;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    event_in = 1'b0;
    busy = 1'b0;
    real_tx = 1'b0;
    bcnt = 0;
    tick();
    tick();
    sb.delete();
    rst = 1'b0;
  endtask

  // Edge is detected two cycles after the rising input, so the stored stamp is the current count + 2.
  task automatic fire(input bit accepted);
    if (accepted) sb.push_back(cnt_m + 40'd2);
    event_in = 1'b1;
    repeat (3) tick();
    event_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || level != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (6) tick();
    chk("drain_done", 40'(sb.size()), 40'd0);
  endtask

  initial begin
    logic [39:0] k;
    int base;
    // reset state
    tick();
    tick();
    chk("rst_dv", 40'(data_valid), 40'd0);
    chk("rst_data", data, 40'd0);
    chk("rst_level", 40'(level), 40'd0);
    chk("rst_ovf", 40'(overflow), 40'd0);
    rst = 1'b0;
    // single event, latency E+2
    repeat (10) tick();
    base = dv_cnt;
    k = cnt_m;
    sb.push_back(k + 40'd2);
    event_in = 1'b1;
    tick();
    tick();
    tick();
    chk("lat_early", 40'(data_valid), 40'd0);
    event_in = 1'b0;
    tick();
    chk("lat_dv", 40'(data_valid), 40'd1);
    tick();
    chk("pulse_width", 40'(data_valid), 40'd0);
    repeat (6) tick();
    chk("single_level", 40'(level), 40'd0);
    chk("single_count", 40'(dv_cnt - base), 40'd1);
    // spacing of 100 cycles under a long busy
    busy = 1'b1;
    k = cnt_m;
    fire(1'b1);
    while (cnt_m != k + 40'd100) tick();
    fire(1'b1);
    chk("spacing_level", 40'(level), 40'd2);
    repeat (4800) tick();
    chk("spacing_hold", 40'(level), 40'd2);
    busy = 1'b0;
    drain(200);
    chk("spacing_diff", last_data - prev_data, 40'd100);
    // handshake pacing with a transmitter-like busy
    real_tx = 1'b1;
    base = dv_cnt;
    repeat (3) begin
      fire(1'b1);
      repeat (10) tick();
    end
    drain(1000);
    chk("handshake_count", 40'(dv_cnt - base), 40'd3);
    repeat (115) tick();
    real_tx = 1'b0;
    busy = 1'b0;
    // overflow: 20 events into 16 entries
    busy = 1'b1;
`ifdef TDC_OVF_MARKER_EN
    sb.push_back(40'hFF00000004);
`endif
    for (int i = 0; i < 20; i++) fire(i < 16);
    chk("ovf_level", 40'(level), 40'd16);
    chk("ovf_flag", 40'(overflow), 40'd1);
    busy = 1'b0;
    drain(300);
    chk("ovf_sticky", 40'(overflow), 40'd1);
    // reset while in SENT
    busy = 1'b1;
    repeat (3) fire(1'b1);
    chk("pre_rst_level", 40'(level), 40'd3);
    busy = 1'b0;
    for (int i = 0; i < 10 && !data_valid; i++) tick();
    chk("rst_sent_dv", 40'(data_valid), 40'd1);
    rst = 1'b1;
    tick();
    chk("rst_sent_dv_low", 40'(data_valid), 40'd0);
    chk("rst_sent_level", 40'(level), 40'd0);
    chk("rst_sent_ovf", 40'(overflow), 40'd0);
    chk("rst_sent_data", data, 40'd0);
    sb.delete();
    rst = 1'b0;
    tick();
    fire(1'b1);
    drain(30);
    // full FIFO with a push in the same cycle as the IDLE pop
    do_reset();
    busy = 1'b1;
    repeat (16) fire(1'b1);
    chk("full_level", 40'(level), 40'd16);
    chk("full_ovf", 40'(overflow), 40'd0);
    sb.push_back(cnt_m + 40'd2);
    event_in = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk("simul_level", 40'(level), 40'd16);
    chk("simul_dv", 40'(data_valid), 40'd1);
    event_in = 1'b0;
    drain(200);
    chk("simul_ovf", 40'(overflow), 40'd0);
    // counter wrap
    do_reset();
    event_in = 1'b1;
    tick();
    force dut.cnt_q = 40'hFFFFFFFFFD;
    #1;
    release dut.cnt_q;
    cnt_m = 40'hFFFFFFFFFD;
    event_in = 1'b0;
    sb.push_back(40'hFFFFFFFFFE);
    sb.push_back(40'h0000000001);
    tick();
    tick();
    event_in = 1'b1;
    tick();
    tick();
    event_in = 1'b0;
    drain(50);
    chk("wrap_level", 40'(level), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
